// File: rtl/mw_writeback_stage.sv
// MEM->WB pipeline register and writeback datapath; one edge from m_* to W outputs.
// Stall (en=0) holds every field; flush/reset load a bubble that never writes the GRF.
module mw_writeback_stage #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       REG_AW   = 5,
   parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic [DATA_W-1:0] m_pc,
   input  logic              m_reg_wen,
   input  logic [REG_AW-1:0] m_reg_addr,
   input  logic [1:0]        m_wb_sel,
   input  logic [DATA_W-1:0] m_alu_out,
   input  logic [DATA_W-1:0] m_mem_rdata,
   input  logic [2:0]        m_load_type,
   input  logic [1:0]        m_byte_off,
   input  logic [DATA_W-1:0] m_mdu_out,
   output logic [DATA_W-1:0] w_pc,
   output logic              w_wen,
   output logic [REG_AW-1:0] w_waddr,
   output logic [DATA_W-1:0] w_wdata,
   output logic              w_valid
);

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_MEM  = 2'd1;
   localparam logic [1:0] SEL_LINK = 2'd2;
   localparam logic [1:0] SEL_MDU  = 2'd3;

   localparam logic [2:0] LD_LW  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LHU = 3'd2;
   localparam logic [2:0] LD_LB  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] pc;
      logic [1:0]        sel;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [2:0]        ltype;
      logic [1:0]        off;
      logic [DATA_W-1:0] mdu;
   } wb_fields_t;

   wb_fields_t wb_q;
   wb_fields_t wb_d;
   wb_fields_t bubble_s;
   wb_fields_t capture_s;

   logic [15:0]       half_s;
   logic [7:0]        byte_s;
   logic [DATA_W-1:0] load_ext_s;
   logic [DATA_W-1:0] link_s;

   always_comb begin
      bubble_s    = '0;
      bubble_s.pc = RESET_PC;
   end

   // $0 is dropped at capture so the forwarding network can trust wen alone.
   always_comb begin
      capture_s       = '0;
      capture_s.valid = 1'b1;
      capture_s.wen   = m_reg_wen & (m_reg_addr != '0);
      capture_s.addr  = m_reg_addr;
      capture_s.pc    = m_pc;
      capture_s.sel   = m_wb_sel;
      capture_s.alu   = m_alu_out;
      capture_s.rdata = m_mem_rdata;
      capture_s.ltype = m_load_type;
      capture_s.off   = m_byte_off;
      capture_s.mdu   = m_mdu_out;
   end

   always_comb begin
      wb_d = wb_q;
      if (flush) begin
         wb_d = bubble_s;
      end else if (en) begin
         wb_d = capture_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_q <= bubble_s;
      end else begin
         wb_q <= wb_d;
      end
   end

   always_comb begin
      half_s = wb_q.off[1] ? wb_q.rdata[31:16] : wb_q.rdata[15:0];
      case (wb_q.off)
         2'd0:    byte_s = wb_q.rdata[7:0];
         2'd1:    byte_s = wb_q.rdata[15:8];
         2'd2:    byte_s = wb_q.rdata[23:16];
         default: byte_s = wb_q.rdata[31:24];
      endcase
   end

   always_comb begin
      case (wb_q.ltype)
         LD_LH:   load_ext_s = {{(DATA_W-16){half_s[15]}}, half_s};
         LD_LHU:  load_ext_s = {{(DATA_W-16){1'b0}}, half_s};
         LD_LB:   load_ext_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
         LD_LBU:  load_ext_s = {{(DATA_W-8){1'b0}}, byte_s};
         LD_LW:   load_ext_s = wb_q.rdata;
         default: load_ext_s = wb_q.rdata;
      endcase
   end

   assign link_s = wb_q.pc + DATA_W'(8);

   always_comb begin
      case (wb_q.sel)
         SEL_ALU:  w_wdata = wb_q.alu;
         SEL_MEM:  w_wdata = load_ext_s;
         SEL_LINK: w_wdata = link_s;
         SEL_MDU:  w_wdata = wb_q.mdu;
         default:  w_wdata = wb_q.alu;
      endcase
   end

   assign w_pc    = wb_q.pc;
   assign w_wen   = wb_q.wen & wb_q.valid;
   assign w_waddr = wb_q.addr;
   assign w_valid = wb_q.valid;

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Directed bench for mw_writeback_stage with hand-computed expectations.
module tb_mw_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        flush;
   logic [31:0] m_pc;
   logic        m_reg_wen;
   logic [4:0]  m_reg_addr;
   logic [1:0]  m_wb_sel;
   logic [31:0] m_alu_out;
   logic [31:0] m_mem_rdata;
   logic [2:0]  m_load_type;
   logic [1:0]  m_byte_off;
   logic [31:0] m_mdu_out;
   logic [31:0] w_pc;
   logic        w_wen;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic        w_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mw_writeback_stage dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .flush       (flush),
      .m_pc        (m_pc),
      .m_reg_wen   (m_reg_wen),
      .m_reg_addr  (m_reg_addr),
      .m_wb_sel    (m_wb_sel),
      .m_alu_out   (m_alu_out),
      .m_mem_rdata (m_mem_rdata),
      .m_load_type (m_load_type),
      .m_byte_off  (m_byte_off),
      .m_mdu_out   (m_mdu_out),
      .w_pc        (w_pc),
      .w_wen       (w_wen),
      .w_waddr     (w_waddr),
      .w_wdata     (w_wdata),
      .w_valid     (w_valid)
   );

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Drive one MEM-stage instruction at negedge, then move to just after the next posedge.
   task automatic apply(input logic [31:0] pc, input logic wen, input logic [4:0] addr,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [2:0] ltype, input logic [1:0] off, input logic [31:0] mdu);
      @(negedge clk);
      m_pc        = pc;
      m_reg_wen   = wen;
      m_reg_addr  = addr;
      m_wb_sel    = sel;
      m_alu_out   = alu;
      m_mem_rdata = rdata;
      m_load_type = ltype;
      m_byte_off  = off;
      m_mdu_out   = mdu;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk_val({tag, "_valid"}, 32'(w_valid), 32'd0);
      chk_val({tag, "_wen"},   32'(w_wen),   32'd0);
      chk_val({tag, "_waddr"}, 32'(w_waddr), 32'd0);
      chk_val({tag, "_pc"},    w_pc,         32'h0000_3000);
      chk_val({tag, "_wdata"}, w_wdata,      32'd0);
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      flush = 1'b0;
      m_pc = '0; m_reg_wen = 1'b0; m_reg_addr = '0; m_wb_sel = '0; m_alu_out = '0;
      m_mem_rdata = '0; m_load_type = '0; m_byte_off = '0; m_mdu_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_bubble("reset");

      reset = 1'b0;
      en    = 1'b1;
      // LB off=3 of 0x80FF_7F01 -> byte 0x80, sign-extended
      apply(32'h3010, 1'b1, 5'd5, 2'd1, 32'h0, 32'h80FF_7F01, 3'd3, 2'd3, 32'h0);
      chk_val("lb_off3_wdata", w_wdata, 32'hFFFF_FF80);
      chk_val("lb_off3_wen",   32'(w_wen),   32'd1);
      chk_val("lb_off3_waddr", 32'(w_waddr), 32'd5);
      chk_val("lb_off3_pc",    w_pc,         32'h0000_3010);
      chk_val("lb_off3_valid", 32'(w_valid), 32'd1);
      apply(32'h3014, 1'b1, 5'd5, 2'd1, 32'h0, 32'h80FF_7F01, 3'd4, 2'd3, 32'h0);
      chk_val("lbu_off3", w_wdata, 32'h0000_0080);
      apply(32'h3018, 1'b1, 5'd6, 2'd1, 32'h0, 32'h80FF_7F01, 3'd3, 2'd1, 32'h0);
      chk_val("lb_off1", w_wdata, 32'h0000_007F);
      apply(32'h301C, 1'b1, 5'd6, 2'd1, 32'h0, 32'h80FF_7F01, 3'd3, 2'd2, 32'h0);
      chk_val("lb_off2", w_wdata, 32'hFFFF_FFFF);
      apply(32'h3020, 1'b1, 5'd6, 2'd1, 32'h0, 32'h80FF_7F01, 3'd4, 2'd0, 32'h0);
      chk_val("lbu_off0", w_wdata, 32'h0000_0001);

      apply(32'h3024, 1'b1, 5'd7, 2'd1, 32'h0, 32'h8001_1234, 3'd1, 2'd2, 32'h0);
      chk_val("lh_off2", w_wdata, 32'hFFFF_8001);
      apply(32'h3028, 1'b1, 5'd7, 2'd1, 32'h0, 32'h0000_F00D, 3'd2, 2'd0, 32'h0);
      chk_val("lhu_off0", w_wdata, 32'h0000_F00D);
      apply(32'h302C, 1'b1, 5'd7, 2'd1, 32'h0, 32'h8001_1234, 3'd1, 2'd3, 32'h0);
      chk_val("lh_off3", w_wdata, 32'hFFFF_8001);
      apply(32'h3030, 1'b1, 5'd7, 2'd1, 32'h0, 32'h0000_9234, 3'd1, 2'd1, 32'h0);
      chk_val("lh_off1", w_wdata, 32'hFFFF_9234);
      apply(32'h3034, 1'b1, 5'd7, 2'd1, 32'h0, 32'h8001_1234, 3'd2, 2'd2, 32'h0);
      chk_val("lhu_off2", w_wdata, 32'h0000_8001);
      apply(32'h3038, 1'b1, 5'd7, 2'd1, 32'h0, 32'hCAFE_BABE, 3'd0, 2'd2, 32'h0);
      chk_val("lw_off2", w_wdata, 32'hCAFE_BABE);
      apply(32'h303C, 1'b1, 5'd7, 2'd1, 32'h0, 32'h1357_9BDF, 3'd6, 2'd3, 32'h0);
      chk_val("ltype6_as_lw", w_wdata, 32'h1357_9BDF);

      apply(32'h0000_3000, 1'b1, 5'd31, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("jal_wdata", w_wdata, 32'h0000_3008);
      chk_val("jal_waddr", 32'(w_waddr), 32'd31);
      apply(32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("link_wrap", w_wdata, 32'h0000_0004);
      apply(32'h3040, 1'b1, 5'd9, 2'd3, 32'h1111, 32'h2222, 3'd0, 2'd0, 32'h55AA);
      chk_val("mdu_sel", w_wdata, 32'h0000_55AA);
      apply(32'h3044, 1'b0, 5'd9, 2'd0, 32'h7777, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("nowen_wen", 32'(w_wen), 32'd0);
      chk_val("nowen_valid", 32'(w_valid), 32'd1);

      apply(32'h3048, 1'b1, 5'd8, 2'd0, 32'h1234, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("alu_wdata", w_wdata, 32'h0000_1234);
      chk_val("alu_waddr", 32'(w_waddr), 32'd8);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply(32'h4000 + 32'(i * 4), 1'b0, 5'(i + 1), 2'(i + 1), 32'hAAAA_0000 + 32'(i),
               32'hFFFF_FFFF, 3'd3, 2'(i), 32'hBBBB_0000);
         chk_val($sformatf("stall%0d_wdata", i), w_wdata, 32'h0000_1234);
         chk_val($sformatf("stall%0d_waddr", i), 32'(w_waddr), 32'd8);
         chk_val($sformatf("stall%0d_wen", i), 32'(w_wen), 32'd1);
         chk_val($sformatf("stall%0d_pc", i), w_pc, 32'h0000_3048);
      end
      flush = 1'b1;
      apply(32'h5000, 1'b1, 5'd10, 2'd0, 32'h9999, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_bubble("flush_stall");
      flush = 1'b0;
      apply(32'h5004, 1'b1, 5'd11, 2'd0, 32'h8888, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_bubble("hold_bubble");

      en = 1'b1;
      apply(32'h5008, 1'b1, 5'd12, 2'd0, 32'h6666, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("resume_wdata", w_wdata, 32'h0000_6666);
      flush = 1'b1;
      apply(32'h500C, 1'b1, 5'd13, 2'd0, 32'h5555, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_bubble("flush_over_en");
      flush = 1'b0;

      apply(32'h5010, 1'b1, 5'd0, 2'd0, 32'hDEAD, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_val("r0_wen",   32'(w_wen),   32'd0);
      chk_val("r0_waddr", 32'(w_waddr), 32'd0);
      chk_val("r0_valid", 32'(w_valid), 32'd1);
      chk_val("r0_wdata", w_wdata, 32'h0000_DEAD);

      reset = 1'b1;
      apply(32'h5014, 1'b1, 5'd14, 2'd0, 32'h4444, 32'h0, 3'd0, 2'd0, 32'h0);
      chk_bubble("reset_over_en");
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
